// File: rtl/door_pkg.sv
// Shared types and default timing constants for the cabin door sequencer.
package door_pkg;

  typedef enum logic [1:0] {
    StClosed,
    StOpening,
    StOpen,
    StClosing
  } door_state_e;

  localparam logic [1:0] MOTOR_IDLE  = 2'b00;
  localparam logic [1:0] MOTOR_OPEN  = 2'b01;
  localparam logic [1:0] MOTOR_CLOSE = 2'b10;

  localparam int unsigned DefOpenTicks = 2;
  localparam int unsigned DefHoldTicks = 3;

endpackage

// File: rtl/door_tick_detect.sv
// Samples the divided door timing level and emits a one-cycle pulse on each rising edge.
module door_tick_detect (
  input  logic clk,
  input  logic rst,
  input  logic door_clk,
  output logic tick
);

  logic door_clk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      door_clk_q <= 1'b0;
    end else begin
      door_clk_q <= door_clk;
    end
  end

  assign tick = door_clk & ~door_clk_q;

endmodule

// File: rtl/door_controller.sv
// Cabin door sequencer: CLOSED -> OPENING -> OPEN -> CLOSING with obstruction reopen.
// Optional reopen limit with sticky fault is enabled by defining REOPEN_LIMIT_EN.
module door_controller
  import door_pkg::*;
#(
  parameter int unsigned OPEN_TICKS = DefOpenTicks,
  parameter int unsigned HOLD_TICKS = DefHoldTicks,
  parameter int unsigned TICK_W     = 4,
  parameter int unsigned MAX_REOPEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       door_clk,
  input  logic       open_req,
  input  logic       close_req,
  input  logic       obstruct,
  input  logic       moving,
  output logic       timer_restart,
  output logic [1:0] door_motor,
  output logic       door_open,
  output logic       door_closed,
  output logic       door_fault
);

  if (MAX_REOPEN < 1 || MAX_REOPEN > 15 || OPEN_TICKS < 1 || HOLD_TICKS < 1 ||
      OPEN_TICKS >= (1 << TICK_W) || HOLD_TICKS >= (1 << TICK_W)) begin : g_bad_params
    $error("door_controller: parameter out of range");
  end

  localparam logic [TICK_W-1:0] OpenLast = TICK_W'(OPEN_TICKS - 1);
  localparam logic [TICK_W-1:0] HoldLast = TICK_W'(HOLD_TICKS - 1);

  door_state_e       state_q, state_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic              restart_d;
  logic [1:0]        motor_d;
  logic              tick;
  logic              fault_q;

  door_tick_detect u_tick (
    .clk      (clk),
    .rst      (rst),
    .door_clk (door_clk),
    .tick     (tick)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    restart_d = 1'b0;
    unique case (state_q)
      StClosed: begin
        if (open_req && !moving) begin
          state_d   = StOpening;
          cnt_d     = '0;
          restart_d = 1'b1;
        end
      end
      StOpening: begin
        if (tick) begin
          if (cnt_q == OpenLast) begin
            state_d = StOpen;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StOpen: begin
        // A faulted door ignores the hold timer and waits for an explicit close.
        if (fault_q) begin
          cnt_d = '0;
          if (close_req) begin
            state_d = StClosing;
          end
        end else if (open_req || obstruct) begin
          cnt_d = '0;
        end else if (close_req || (tick && cnt_q == HoldLast)) begin
          state_d = StClosing;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StClosing: begin
        // Reopen has priority over completing the close.
        if (obstruct || open_req) begin
          state_d   = StOpening;
          cnt_d     = '0;
          restart_d = 1'b1;
        end else if (tick) begin
          if (cnt_q == OpenLast) begin
            state_d = StClosed;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StClosed;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    unique case (state_d)
      StOpening: motor_d = MOTOR_OPEN;
      StClosing: motor_d = MOTOR_CLOSE;
      default:   motor_d = MOTOR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StClosed;
      cnt_q         <= '0;
      timer_restart <= 1'b0;
      door_motor    <= MOTOR_IDLE;
      door_open     <= 1'b0;
      door_closed   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timer_restart <= restart_d;
      door_motor    <= motor_d;
      door_open     <= (state_d == StOpen);
      door_closed   <= (state_d == StClosed);
    end
  end

`ifdef REOPEN_LIMIT_EN
  localparam logic [3:0] MaxReopen = 4'(MAX_REOPEN);

  logic [3:0] reopen_q, reopen_d;
  logic       fault_d;

  always_comb begin
    reopen_d = reopen_q;
    fault_d  = fault_q;
    if (state_d == StClosed) begin
      reopen_d = '0;
      fault_d  = 1'b0;
    end else if (state_q == StClosing && state_d == StOpening) begin
      if (reopen_q != 4'hf) begin
        reopen_d = reopen_q + 1'b1;
      end
      if (reopen_d == MaxReopen) begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reopen_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      reopen_q <= reopen_d;
      fault_q  <= fault_d;
    end
  end

  assign door_fault = fault_q;
`else
  assign fault_q    = 1'b0;
  assign door_fault = 1'b0;
`endif

endmodule

// File: tb/tb_door_controller.sv
// Directed self-checking bench for door_controller (OPEN_TICKS=2, HOLD_TICKS=3).
module tb_door_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       door_clk = 1'b0;
  logic       open_req = 1'b0;
  logic       close_req = 1'b0;
  logic       obstruct = 1'b0;
  logic       moving = 1'b0;
  logic       timer_restart;
  logic [1:0] door_motor;
  logic       door_open;
  logic       door_closed;
  logic       door_fault;

  int tests = 0;
  int fails = 0;

  door_controller #(
    .OPEN_TICKS (2),
    .HOLD_TICKS (3),
    .TICK_W     (4),
    .MAX_REOPEN (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .door_clk      (door_clk),
    .open_req      (open_req),
    .close_req     (close_req),
    .obstruct      (obstruct),
    .moving        (moving),
    .timer_restart (timer_restart),
    .door_motor    (door_motor),
    .door_open     (door_open),
    .door_closed   (door_closed),
    .door_fault    (door_fault)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One rising edge of the door timing level, then back low.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      door_clk = 1'b1;
      step();
      door_clk = 1'b0;
      step();
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // closed, open, motor, restart
  task automatic chk_all(input string tag, input logic cl, input logic op,
                         input logic [1:0] mo, input logic tr);
    chk({tag, ".closed"}, {1'b0, door_closed}, {1'b0, cl});
    chk({tag, ".open"}, {1'b0, door_open}, {1'b0, op});
    chk({tag, ".motor"}, door_motor, mo);
    chk({tag, ".restart"}, {1'b0, timer_restart}, {1'b0, tr});
  endtask

  initial begin
    // Reset state
    step(3);
    chk_all("reset", 1, 0, 2'b00, 0);
    chk("reset.fault", {1'b0, door_fault}, 2'b00);
    rst = 1'b0;
    step();

    // Full open / hold / close cycle
    open_req = 1'b1;
    step();
    chk_all("open_start", 0, 0, 2'b01, 1);
    open_req = 1'b0;
    step();
    chk_all("restart_single", 0, 0, 2'b01, 0);
    // Level held high across several cycles counts as one tick.
    door_clk = 1'b1;
    step(3);
    door_clk = 1'b0;
    step();
    chk_all("opening_one_tick", 0, 0, 2'b01, 0);
    tick();
    chk_all("opened", 0, 1, 2'b00, 0);
    tick(2);
    chk_all("hold_2", 0, 1, 2'b00, 0);
    tick();
    chk_all("hold_done", 0, 0, 2'b10, 0);
    tick();
    chk_all("closing_1", 0, 0, 2'b10, 0);
    tick();
    chk_all("closed", 1, 0, 2'b00, 0);

    // moving blocks open_req
    moving   = 1'b1;
    open_req = 1'b1;
    step(3);
    chk_all("moving_block", 1, 0, 2'b00, 0);
    moving = 1'b0;
    step();
    chk_all("moving_drop", 0, 0, 2'b01, 1);
    open_req = 1'b0;
    tick(2);
    chk_all("opened_2", 0, 1, 2'b00, 0);

    // close_req after one hold tick
    tick();
    close_req = 1'b1;
    step();
    chk_all("close_req", 0, 0, 2'b10, 0);
    close_req = 1'b0;

    // obstruct during CLOSING after one tick, counter restarts
    tick();
    obstruct = 1'b1;
    step();
    chk_all("reopen", 0, 0, 2'b01, 1);
    obstruct = 1'b0;
    tick();
    chk_all("reopen_cnt0", 0, 0, 2'b01, 0);
    tick();
    chk_all("reopened", 0, 1, 2'b00, 0);

    // close_req together with obstruct: stay open, hold counter cleared
    tick(2);
    close_req = 1'b1;
    obstruct  = 1'b1;
    step();
    chk_all("close_obstruct", 0, 1, 2'b00, 0);
    close_req = 1'b0;
    obstruct  = 1'b0;
    tick(2);
    chk_all("hold_restarted", 0, 1, 2'b00, 0);
    tick();
    chk_all("hold_restart_done", 0, 0, 2'b10, 0);

    // Reopen wins over terminal close tick
    tick();
    door_clk = 1'b1;
    obstruct = 1'b1;
    step();
    chk_all("collision_reopen", 0, 0, 2'b01, 1);
    door_clk = 1'b0;
    obstruct = 1'b0;
    step();
    tick(2);
    chk_all("collision_open", 0, 1, 2'b00, 0);
    close_req = 1'b1;
    step();
    close_req = 1'b0;
    tick(2);
    chk_all("closed_2", 1, 0, 2'b00, 0);

    // Reset mid-OPENING
    open_req = 1'b1;
    step();
    open_req = 1'b0;
    rst = 1'b1;
    step();
    chk_all("rst_mid", 1, 0, 2'b00, 0);
    rst = 1'b0;
    step(2);
    chk_all("rst_after", 1, 0, 2'b00, 0);

`ifdef REOPEN_LIMIT_EN
    open_req = 1'b1;
    step();
    open_req = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      tick(2);
      tick(3);
      obstruct = 1'b1;
      step();
      obstruct = 1'b0;
      chk($sformatf("fault_after_%0d", r), {1'b0, door_fault}, {1'b0, (r == 3)});
    end
    tick(2);
    chk_all("fault_open", 0, 1, 2'b00, 0);
    obstruct = 1'b1;
    step();
    obstruct = 1'b0;
    tick(5);
    chk_all("fault_held", 0, 1, 2'b00, 0);
    close_req = 1'b1;
    step();
    close_req = 1'b0;
    chk_all("fault_close", 0, 0, 2'b10, 0);
    chk("fault_sticky", {1'b0, door_fault}, 2'b01);
    tick(2);
    chk_all("fault_closed", 1, 0, 2'b00, 0);
    chk("fault_cleared", {1'b0, door_fault}, 2'b00);
`else
    chk("fault_tied", {1'b0, door_fault}, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
